// File: rtl/spc_ram_arbiter_pkg.sv
// Shared types and defaults for the DSP/CPU single-port RAM arbiter.
package spc_ram_arbiter_pkg;
  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_DSP  = 2'd1,
    SEL_CPU  = 2'd2
  } port_sel_e;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } trk_state_e;
endpackage

// File: rtl/arb_port_tracker.sv
// Per-port access tracker: goes PENDING for the cycle after a grant, which is
// exactly the ack cycle, and forwards RAM read data only while acking.
module arb_port_tracker
  import spc_ram_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              grant,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              ack,
  output logic [DATA_W-1:0] rdata
);
  trk_state_e state_q, state_d;

  always_comb begin
    state_d = ST_IDLE;
    if (grant) state_d = ST_PENDING;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  assign ack   = (state_q == ST_PENDING);
  assign rdata = ack ? ram_rdata : '0;
endmodule

// File: rtl/spc_ram_arbiter.sv
// Two-port (DSP, CPU) arbiter for a shared single-port synchronous RAM.
// DSP has priority; a saturating starvation counter hands the slot to the CPU.
module spc_ram_arbiter
  import spc_ram_arbiter_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              dsp_req,
  input  logic [ADDR_W-1:0] dsp_addr,
  input  logic [DATA_W-1:0] dsp_wdata,
  input  logic              dsp_we,
  output logic              dsp_ack,
  output logic [DATA_W-1:0] dsp_rdata,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_we,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_write_enable,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  port_sel_e  sel;
  logic       dsp_elig, cpu_elig;
  logic [3:0] starve_cnt_q, starve_cnt_d;

  // A port still acking its previous access is not eligible, so a held req
  // is never re-issued. Reset gates the grant so RAM drives drop immediately.
  always_comb begin
    dsp_elig = dsp_req & ~dsp_ack;
    cpu_elig = cpu_req & ~cpu_ack;
    sel      = SEL_NONE;
    if (reset) begin
      if (dsp_elig && cpu_elig) sel = (starve_cnt_q == LIMIT) ? SEL_CPU : SEL_DSP;
      else if (dsp_elig)        sel = SEL_DSP;
      else if (cpu_elig)        sel = SEL_CPU;
    end
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!cpu_req || sel == SEL_CPU)
      starve_cnt_d = '0;
    else if (sel == SEL_DSP && cpu_elig && starve_cnt_q < LIMIT)
      starve_cnt_d = starve_cnt_q + 4'd1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) starve_cnt_q <= '0;
    else        starve_cnt_q <= starve_cnt_d;
  end

  always_comb begin
    ram_address      = '0;
    ram_wdata        = '0;
    ram_write_enable = 1'b0;
    case (sel)
      SEL_DSP: begin
        ram_address      = dsp_addr;
        ram_wdata        = dsp_wdata;
        ram_write_enable = dsp_we;
      end
      SEL_CPU: begin
        ram_address      = cpu_addr;
        ram_wdata        = cpu_wdata;
        ram_write_enable = cpu_we;
      end
      default: ;
    endcase
  end

  assign busy = (sel != SEL_NONE) | dsp_ack | cpu_ack;

  arb_port_tracker #(.DATA_W(DATA_W)) u_dsp_trk (
    .clock    (clock),
    .reset    (reset),
    .grant    (sel == SEL_DSP),
    .ram_rdata(ram_rdata),
    .ack      (dsp_ack),
    .rdata    (dsp_rdata)
  );

  arb_port_tracker #(.DATA_W(DATA_W)) u_cpu_trk (
    .clock    (clock),
    .reset    (reset),
    .grant    (sel == SEL_CPU),
    .ram_rdata(ram_rdata),
    .ack      (cpu_ack),
    .rdata    (cpu_rdata)
  );
endmodule
